// File: rtl/reaction_timer.sv
// reaction_timer: BCD millisecond reaction timer with false-start/timeout detection.
// Optional best-time tracking is compiled in with BEST_TIME_EN.
module reaction_timer #(
  parameter logic [15:0] TIMEOUT_BCD = 16'h9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_ms,
  input  logic        arm,
  input  logic        go,
  input  logic        key_n,
  output logic [3:0]  bcd0,
  output logic [3:0]  bcd1,
  output logic [3:0]  bcd2,
  output logic [3:0]  bcd3,
  output logic        valid,
  output logic        false_start,
  output logic        timeout,
  output logic        busy
`ifdef BEST_TIME_EN
  ,
  output logic [15:0] best_bcd,
  output logic        best_new
`endif
);
  typedef enum logic [1:0] {IDLE, ARMED, TIMING, DONE} state_t;
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  flag_q, flag_d;
  logic        s1_q, s2_q, s3_q, press;
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      r[4*i+:4] = c ? (v[4*i+:4] == 4'd9 ? 4'd0 : v[4*i+:4] + 4'd1) : v[4*i+:4];
      c = c & (v[4*i+:4] == 4'd9);
    end
    return r;
  endfunction
  // Only a fresh falling edge of the synchronised key counts as a press.
  assign press = s3_q & ~s2_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flag_d  = flag_q;
    if (arm) begin
      state_d = ARMED;
      cnt_d   = '0;
      flag_d  = '0;
    end else begin
      case (state_q)
        ARMED: begin
          if (press) begin
            state_d = DONE;
            flag_d  = 3'b010;
          end else if (go) state_d = TIMING;
        end
        TIMING: begin
          if (press) begin
            state_d = DONE;
            flag_d  = 3'b100;
          end else if (tick_ms) begin
            if (cnt_q == TIMEOUT_BCD) begin
              state_d = DONE;
              flag_d  = 3'b001;
            end else cnt_d = bcd_inc(cnt_q);
          end
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      flag_q  <= '0;
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      s3_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
      s1_q    <= key_n;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
    end
  end
  assign {bcd3, bcd2, bcd1, bcd0}     = cnt_q;
  assign {valid, false_start, timeout} = flag_q;
  assign busy = (state_q == ARMED) || (state_q == TIMING);
`ifdef BEST_TIME_EN
  logic [15:0] best_q;
  logic        best_new_q, better;
  // BCD ordering matches binary ordering, so a plain compare suffices.
  assign better = (state_q == TIMING) && !arm && press && (cnt_q < best_q);
  always_ff @(posedge clk) begin
    if (rst) begin
      best_q     <= 16'h9999;
      best_new_q <= 1'b0;
    end else begin
      best_q     <= better ? cnt_q : best_q;
      best_new_q <= better;
    end
  end
  assign best_bcd = best_q;
  assign best_new = best_new_q;
`endif
endmodule

// File: doc/reaction_timer.md
REACTION_TIMER -- requirements
Module: reaction_timer

Interface
REQ-001 Parameter: TIMEOUT_BCD, 16'h9999, BCD count at which timing aborts (four BCD digits, each 0-9).
REQ-002 Port: clk  in  1  system clock, 50 MHz.
REQ-003 Port: rst  in  1  synchronous, active-high reset.
REQ-004 Port: tick_ms  in  1  one-clk pulse per millisecond.
REQ-005 Port: arm  in  1  one-clk pulse; starts a new trial (light sequence begins).
REQ-006 Port: go  in  1  one-clk pulse; lights out, timing starts.
REQ-007 Port: key_n  in  1  raw push-button, active-low, asynchronous to clk.
REQ-008 Port: bcd0..bcd3  out  4 each  reaction time in ms, BCD; bcd0 = units.
REQ-009 Port: valid  out  1  level; result holds a genuine reaction time.
REQ-010 Port: false_start  out  1  level; key pressed before go.
REQ-011 Port: timeout  out  1  level; no press before TIMEOUT_BCD.
REQ-012 Port: busy  out  1  high in ARMED or TIMING.

Function
REQ-013 key_n shall pass through a 2-flop synchroniser; press = sync2 low while previous sync2 high (falling edge), one-clk internal pulse.
REQ-014 A key held low across arm shall not count as a press; only a new falling edge counts.
REQ-015 FSM states: IDLE, ARMED, TIMING, DONE; registered; state and outputs update on the clk edge after the qualifying input.
REQ-016 IDLE: arm -> ARMED; counter cleared to 0000; valid, false_start, timeout cleared.
REQ-017 ARMED: press -> DONE with false_start=1, count 0000; otherwise go -> TIMING.
REQ-018 ARMED: press and go in the same cycle -> DONE with false_start=1.
REQ-019 TIMING: each tick_ms increments the 4-digit BCD counter with decimal carry (digit 9 -> 0, carry up).
REQ-020 TIMING: press -> DONE with valid=1, count frozen.
REQ-021 TIMING: press and tick_ms in the same cycle -> press wins, count not incremented.
REQ-022 TIMING: tick_ms while count == TIMEOUT_BCD -> DONE with timeout=1, count held at TIMEOUT_BCD, never wraps.
REQ-023 DONE: outputs held indefinitely; arm -> ARMED with the same clears as REQ-016; press and go ignored.
REQ-024 arm in ARMED or TIMING shall restart the trial: counter cleared, state ARMED.
REQ-025 valid, false_start and timeout are mutually exclusive; at most one is high.
REQ-026 tick_ms outside TIMING shall have no effect.

Reset
REQ-027 rst has priority over all inputs and applies on the clk edge where it is sampled high.
REQ-028 Reset values: state IDLE; bcd0..bcd3 = 0; valid, false_start, timeout, busy = 0; both synchroniser flops = 1 (released key).
REQ-029 rst mid-trial aborts the trial; no flag is raised.

Configuration
REQ-030 Macro BEST_TIME_EN compiled in: add ports best_bcd (out, 16) and best_new (out, 1).
REQ-031 With BEST_TIME_EN: best_bcd resets to 16'h9999 and loads the frozen count on entry to DONE with valid=1 only if that count is below best_bcd.
REQ-032 With BEST_TIME_EN: best_new pulses for one clk when best_bcd is updated; false starts and timeouts never update it.
REQ-033 Without BEST_TIME_EN: no best_bcd or best_new ports and no related logic; all other behaviour identical.

Verification
REQ-034 rst, arm, go, then 237 tick_ms pulses, then key_n falls -> DONE, bcd = 0237, valid=1, busy=0.
REQ-035 arm, key_n falls before go -> false_start=1, bcd = 0000; a later go does not leave DONE.
REQ-036 arm, go, then 10000 ticks with key_n high -> timeout=1, bcd = 9999 after tick 9999, held through further ticks.
REQ-037 Count at 0099, key press and tick in the same cycle -> bcd = 0099, valid=1; separately 0099 + tick -> 0100.
REQ-038 key_n held low through arm and go, 50 ticks, then released and pressed -> no false start, valid=1, bcd = 0050.
REQ-039 BEST_TIME_EN: trials of 0300, 0180, 0250 ms -> best_bcd 0300, 0180, 0180; best_new pulses twice; rst -> best_bcd = 9999.
